nine_seg_dice_roller: RTL and testbench

//  Multi-die electronic dice. A roll request runs a decelerating animation on NUM_DICE

---
 rtl/nine_seg_pkg.sv | 24 ++
 rtl/nine_seg_face_decode.sv | 11 +
 rtl/nine_seg_dice_roller.sv | 108 ++++++++++
 tb/tb_nine_seg_dice_roller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/nine_seg_pkg.sv
// Shared types, pip table and face-advance helper for the nine-segment dice roller.
package nine_seg_pkg;

    typedef logic [8:0] seg_t;
    typedef logic [2:0] face_t;

    typedef enum logic {IDLE, ROLL} state_t;

    // Columns left/mid/right, each top/mid/bottom, MSB first.
    localparam seg_t FACE_SEG [0:7] = '{
        9'b000000000, 9'b000010000, 9'b100000001, 9'b100010001,
        9'b101000101, 9'b101010101, 9'b111000111, 9'b111010111
    };

    // Advance a face by 1..4 with wrap; a blank face lands in 1..4.
    function automatic face_t face_step(input face_t f, input logic [1:0] r, input int max_face);
        logic [3:0] s;
        s = {1'b0, f} + 4'd1 + {2'b00, r};
        if (s > 4'(max_face))
            s = s - 4'(max_face);
        return s[2:0];
    endfunction

endpackage

// File: rtl/nine_seg_face_decode.sv
// Face value to nine-segment pip pattern, purely combinational.
module nine_seg_face_decode
    import nine_seg_pkg::*;
(
    input  logic [2:0] face,
    output logic [8:0] seg
);

    assign seg = FACE_SEG[face];

endmodule

// File: rtl/nine_seg_dice_roller.sv
// Multi-die roller: edge-triggered decelerating animation driven by a free-running LFSR.
module nine_seg_dice_roller
    import nine_seg_pkg::*;
#(
    parameter int          NUM_DICE   = 2,
    parameter int          MAX_FACE   = 6,
    parameter int          TICK_DIV   = 50000,
    parameter int          ROLL_STEPS = 12,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    roll_i,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [3*NUM_DICE-1:0]   face_o,
    output logic [9*NUM_DICE-1:0]   seg_o
);

    localparam int CW = $clog2(TICK_DIV*ROLL_STEPS + 1);
    localparam int SW = $clog2(ROLL_STEPS + 1);

    state_t                 state, state_nx;
    logic [15:0]            lfsr;
    logic                   roll_q;
    logic [CW-1:0]          tick, reload;
    logic [SW-1:0]          step;
    face_t [NUM_DICE-1:0]   faces, faces_nx;
    logic                   start, step_end, last_step;

    assign start     = roll_i & ~roll_q;
    assign step_end  = (tick == reload - CW'(1));
    assign last_step = (step == SW'(ROLL_STEPS-1));

    // LFSR and edge register run in every state so a held button never retriggers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr   <= SEED;
            roll_q <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            roll_q <= roll_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            faces  <= '0;
            tick   <= '0;
            step   <= '0;
            reload <= '0;
        end else begin
            state <= state_nx;
            faces <= faces_nx;
            // Each step lasts one TICK_DIV longer than the previous one.
            if (state == IDLE) begin
                tick   <= '0;
                step   <= '0;
                reload <= CW'(TICK_DIV);
            end else if (step_end) begin
                tick   <= '0;
                step   <= step + SW'(1);
                reload <= reload + CW'(TICK_DIV);
            end else begin
                tick   <= tick + CW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        faces_nx = faces;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = ROLL;
                else if (clear_i)
                    faces_nx = '0;
            end
            ROLL: begin
                busy_o = 1'b1;
                if (step_end) begin
                    for (int i = 0; i < NUM_DICE; i++)
                        faces_nx[i] = face_step(faces[i], lfsr[2*i +: 2], MAX_FACE);
                    if (last_step) begin
                        done_o   = ~reset;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign face_o = faces;

    for (genvar g = 0; g < NUM_DICE; g++) begin : g_die
        nine_seg_face_decode u_dec (
            .face (faces[g]),
            .seg  (seg_o[9*g +: 9])
        );
    end

endmodule

// File: tb/tb_nine_seg_dice_roller.sv
// Directed bench for the dice roller: timing, edge handling, clear, reset and face ranges.
module tb_nine_seg_dice_roller;

    logic        clk = 1'b0;
    logic        reset, roll, clear, busy, done;
    logic [5:0]  face;
    logic [17:0] seg;
    logic        roll4, busy4, done4;
    logic [5:0]  face4;
    logic [17:0] seg4;
    logic [2:0]  dface;
    logic [8:0]  dseg;
    logic [5:0]  saved;
    int          nchk = 0, nerr = 0, nbusy = 0, ndone = 0;

    logic [8:0] seg_tab [8] = '{
        9'b000000000, 9'b000010000, 9'b100000001, 9'b100010001,
        9'b101000101, 9'b101010101, 9'b111000111, 9'b111010111
    };

    always #5 clk = ~clk;

    nine_seg_dice_roller #(.NUM_DICE(2), .MAX_FACE(6), .TICK_DIV(2), .ROLL_STEPS(4)) u_dut (
        .clk(clk), .reset(reset), .roll_i(roll), .clear_i(clear),
        .busy_o(busy), .done_o(done), .face_o(face), .seg_o(seg)
    );

    nine_seg_dice_roller #(.NUM_DICE(2), .MAX_FACE(4), .TICK_DIV(2), .ROLL_STEPS(4)) u_d4 (
        .clk(clk), .reset(reset), .roll_i(roll4), .clear_i(1'b0),
        .busy_o(busy4), .done_o(done4), .face_o(face4), .seg_o(seg4)
    );

    nine_seg_face_decode u_dec (.face(dface), .seg(dseg));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            nbusy += int'(busy);
            ndone += int'(done);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy; k++) step_n(1);
        check(tag, busy, 0);
    endtask

    // Both dice in 1..maxf and each pattern matches the pip table.
    function automatic bit dice_ok(input logic [5:0] f, input logic [17:0] s, input int maxf);
        bit ok;
        logic [2:0] fi;
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fi = f[3*i +: 3];
            if (fi < 3'd1 || int'(fi) > maxf) ok = 1'b0;
            if (s[9*i +: 9] !== seg_tab[fi]) ok = 1'b0;
        end
        return ok;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; roll = 1'b0; clear = 1'b0; roll4 = 1'b0; dface = 3'd0;
        step_n(3);
        check("rst_face", face, 0);
        check("rst_seg", seg, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_face4", face4, 0);
        reset = 1'b0;

        // Held button: one roll of 2+4+6+8 cycles
        nbusy = 0; ndone = 0;
        roll = 1'b1;
        step_n(40);
        check("t2_busy_len", nbusy, 20);
        check("t2_done_cnt", ndone, 1);
        check("t2_faces", dice_ok(face, seg, 6), 1);

        // Edge during ROLL is ignored
        roll = 1'b0; step_n(2);
        nbusy = 0; ndone = 0;
        roll = 1'b1; step_n(3);
        roll = 1'b0; step_n(2);
        roll = 1'b1; step_n(33);
        check("t3_busy_len", nbusy, 20);
        check("t3_done_cnt", ndone, 1);
        check("t3_faces", dice_ok(face, seg, 6), 1);
        roll = 1'b0; step_n(1);
        roll = 1'b1; step_n(1);
        check("t3_restart", busy, 1);
        roll = 1'b0;
        wait_idle("t3_idle");

        // Reset in step 2 (roll cycle 8)
        roll = 1'b1; step_n(1);
        roll = 1'b0; step_n(7);
        check("t4_busy_pre", busy, 1);
        check("t4_faces_pre", dice_ok(face, seg, 6), 1);
        ndone = 0;
        reset = 1'b1; step_n(1);
        check("t4_busy", busy, 0);
        check("t4_face", face, 0);
        check("t4_seg", seg, 0);
        reset = 1'b0; step_n(25);
        check("t4_no_done", ndone, 0);

        // Clear in IDLE, and start winning over clear
        roll = 1'b1; step_n(1);
        roll = 1'b0;
        wait_idle("t5_idle_a");
        check("t5_faces_a", dice_ok(face, seg, 6), 1);
        clear = 1'b1; step_n(1);
        clear = 1'b0;
        check("t5_clr_face", face, 0);
        check("t5_clr_seg", seg, 0);
        roll = 1'b1; step_n(1);
        roll = 1'b0;
        wait_idle("t5_idle_b");
        saved = face;
        check("t5_faces_b", dice_ok(face, seg, 6), 1);
        clear = 1'b1; roll = 1'b1; step_n(1);
        roll = 1'b0;
        check("t5_start_wins", busy, 1);
        check("t5_no_clear", face, saved);
        wait_idle("t5_idle_c");
        clear = 1'b0;
        check("t5_clear_ignored", dice_ok(face, seg, 6), 1);

        for (int f = 0; f < 8; f++) begin
            dface = 3'(f);
            #1;
            check($sformatf("dec_%0d", f), dseg, seg_tab[f]);
        end

        // MAX_FACE=4 soak
        for (int r = 0; r < 500; r++) begin
            roll4 = 1'b1; step_n(1);
            roll4 = 1'b0;
            for (int k = 0; k < 40 && !done4; k++) step_n(1);
            check("t6_done", done4, 1);
            step_n(1);
            check("t6_range", dice_ok(face4, seg4, 4), 1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
